dcache_2way: RTL and testbench

DCACHE_2WAY -- requirements
Module: dcache_2way

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_way.sv | 56 +++++
 rtl/dcache_2way.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_2way.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the two-way write-back data cache.
// Optional hit/miss counters are enabled with the DCACHE_PERF_CNT_EN macro.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_WORD_W   = 32;
    localparam int DEF_LINE_W   = 256;
    localparam int DEF_SETS     = 32;
    localparam int DEF_OFFSET_W = $clog2(DEF_LINE_W / 8);
    localparam int DEF_INDEX_W  = $clog2(DEF_SETS);
    localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_OFFSET_W - DEF_INDEX_W;

    function automatic int offset_width(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty/tag/line storage per set plus the tag compare.
// All accesses (lookup and write) use the single set index presented by the top.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int TAG_W   = DEF_TAG_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int LINE_W  = DEF_LINE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    output logic               valid,
    output logic               dirty,
    output logic [TAG_W-1:0]   line_tag,
    output logic [LINE_W-1:0]  line,
    input  logic               wr_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line,
    input  logic               wr_dirty
);

    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] line_mem [SETS];

    // Status bits are cleared by reset; tags and data are left as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[index]  <= wr_tag;
            line_mem[index] <= wr_line;
        end
    end

    assign valid    = valid_q[index];
    assign dirty    = dirty_q[index];
    assign line_tag = tag_mem[index];
    assign line     = line_mem[index];
    assign hit      = valid_q[index] && (tag_mem[index] == tag);

endmodule

// File: rtl/dcache_2way.sv
// Two-way set-associative write-back, write-allocate data cache with LRU replacement.
// Define DCACHE_PERF_CNT_EN to enable saturating hit/miss counters.
module dcache_2way
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int SETS   = DEF_SETS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [WORD_W-1:0]   cpu_wdata_i,
    input  logic [WORD_W/8-1:0] cpu_be_i,
    input  logic                cpu_read_i,
    input  logic                cpu_write_i,
    output logic [WORD_W-1:0]   cpu_rdata_o,
    output logic                cpu_stall_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_wdata_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    input  logic [LINE_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
);

    localparam int OFFSET_W = offset_width(LINE_W);
    localparam int INDEX_W  = index_width(SETS);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int BYTES_W  = $clog2(WORD_W / 8);
    localparam int WSEL_W   = OFFSET_W - BYTES_W;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:BYTES_W]  req_addr_q;
    logic [ADDR_W-1:BYTES_W]  lookup;
    logic                     victim_q;
    logic [SETS-1:0]          lru_q;
    logic                     addr_unused;

    logic [INDEX_W-1:0]       index;
    logic [TAG_W-1:0]         tag;
    logic [WSEL_W-1:0]        word_sel;

    logic                     way_hit   [2];
    logic                     way_valid [2];
    logic                     way_dirty [2];
    logic [TAG_W-1:0]         way_tag   [2];
    logic [LINE_W-1:0]        way_line  [2];
    logic [1:0]               wr_en;
    logic [LINE_W-1:0]        wr_line;
    logic                     wr_dirty;

    logic                     req;
    logic                     hit_any;
    logic                     hit_way;
    logic                     acc_way;
    logic                     victim;
    logic [LINE_W-1:0]        acc_line;
    logic [WORD_W-1:0]        rd_word;
    logic [LINE_W-1:0]        merged_line;
    logic                     store_en;
    logic                     lru_we;
    logic                     lru_val;

    assign addr_unused = ^cpu_addr_i[BYTES_W-1:0];

    // Once a miss leaves IDLE the cache works on the latched address.
    assign lookup   = (state_q == IDLE) ? cpu_addr_i[ADDR_W-1:BYTES_W] : req_addr_q;
    assign index    = lookup[OFFSET_W +: INDEX_W];
    assign tag      = lookup[ADDR_W-1 -: TAG_W];
    assign word_sel = lookup[BYTES_W +: WSEL_W];

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_way #(
            .TAG_W   (TAG_W),
            .INDEX_W (INDEX_W),
            .LINE_W  (LINE_W)
        ) u_way (
            .clk      (clk_i),
            .rst      (rst_i),
            .index    (index),
            .tag      (tag),
            .hit      (way_hit[w]),
            .valid    (way_valid[w]),
            .dirty    (way_dirty[w]),
            .line_tag (way_tag[w]),
            .line     (way_line[w]),
            .wr_en    (wr_en[w]),
            .wr_tag   (tag),
            .wr_line  (wr_line),
            .wr_dirty (wr_dirty)
        );
    end

    assign req      = cpu_read_i | cpu_write_i;
    assign hit_any  = way_hit[0] | way_hit[1];
    assign hit_way  = way_hit[1];
    assign acc_way  = (state_q == RESPOND) ? victim_q : hit_way;
    assign acc_line = way_line[acc_way];
    assign rd_word  = acc_line[word_sel*WORD_W +: WORD_W];
    assign store_en = cpu_write_i && (|cpu_be_i);

    // Prefer an empty way (way 0 first); only evict the LRU way when the set is full.
    assign victim = !way_valid[0] ? 1'b0 :
                    !way_valid[1] ? 1'b1 : lru_q[index];

    always_comb begin
        merged_line = acc_line;
        for (int b = 0; b < WORD_W / 8; b++) begin
            if (cpu_be_i[b]) begin
                merged_line[word_sel*WORD_W + b*8 +: 8] = cpu_wdata_i[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b0;
        cpu_rdata_o  = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        wr_en        = 2'b00;
        wr_line      = merged_line;
        wr_dirty     = 1'b1;
        lru_we       = 1'b0;
        lru_val      = ~acc_way;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit_any) begin
                        cpu_rdata_o     = rd_word;
                        wr_en[hit_way]  = store_en;
                        lru_we          = 1'b1;
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = way_dirty[victim] && way_valid[victim] ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {way_tag[victim_q], index, {OFFSET_W{1'b0}}};
                mem_wdata_o  = way_line[victim_q];
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    wr_en[victim_q] = 1'b1;
                    wr_line         = mem_rdata_i;
                    wr_dirty        = 1'b0;
                    lru_we          = 1'b1;
                    lru_val         = ~victim_q;
                    state_d         = RESPOND;
                end
            end
            RESPOND: begin
                cpu_rdata_o     = rd_word;
                wr_en[victim_q] = store_en;
                lru_we          = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            if (lru_we) begin
                lru_q[index] <= lru_val;
            end
        end
    end

    // The last address and victim seen in IDLE belong to the miss being serviced.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE) begin
            req_addr_q <= cpu_addr_i[ADDR_W-1:BYTES_W];
            victim_q   <= victim;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && req) begin
            if (hit_any) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// Scoreboard bench for dcache_2way: directed CPU accesses against a behavioural memory.
// Expected counter values follow DCACHE_PERF_CNT_EN.
module tb_dcache_2way;

    typedef struct {
        logic [31:0] rdata;
        bit          is_hit;
    } cpu_exp_t;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] word0;
    } mem_exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [3:0]   cpu_be_i;
    logic         cpu_read_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int last_ack_cyc = -10;
    int resp_cnt = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int wait_cnt = 0;
    int ack_delay = 5;
    bit auto_resp = 1'b1;

    cpu_exp_t     cpu_q[$];
    mem_exp_t     mem_q[$];
    logic [255:0] mem_lines [logic [31:0]];

    dcache_2way dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_be_i     (cpu_be_i),
        .cpu_read_i   (cpu_read_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Untouched memory lines hold word k = {line_addr[23:0], k}.
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (mem_lines.exists(a)) return mem_lines[a];
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[23:0], 8'(k)};
        return l;
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef DCACHE_PERF_CNT_EN
        return n;
`else
        return n * 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectMem(input bit write, input logic [31:0] addr, input logic [31:0] word0);
        mem_exp_t m;
        m.write = write;
        m.addr  = addr;
        m.word0 = word0;
        mem_q.push_back(m);
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input bit is_hit, input logic [31:0] exp_rdata);
        cpu_exp_t e;
        int start;
        @(negedge clk_i);
        e.rdata  = exp_rdata;
        e.is_hit = is_hit;
        cpu_q.push_back(e);
        if (is_hit) exp_hits++;
        else exp_misses++;
        cpu_read_i  = rd;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        cpu_be_i    = be;
        issue_cyc   = cyc;
        start       = resp_cnt;
        for (int i = 0; i < 200; i++) begin
            #2;
            if (resp_cnt != start) break;
            @(negedge clk_i);
        end
        #2;
        checks++;
        if (resp_cnt == start) begin
            failures++;
            $display("[TB] FAIL access_timeout: addr 0x%08h got no response, required one", addr);
            cpu_read_i  = 1'b0;
            cpu_write_i = 1'b0;
            void'(cpu_q.pop_back());
        end
    endtask

    task automatic goIdle();
        @(negedge clk_i);
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
    endtask

    // Memory responder: acks the current request after ack_delay cycles.
    initial forever begin
        @(negedge clk_i);
        if (auto_resp) begin
            mem_ack_i = 1'b0;
            if (mem_enable_o && !rst_i) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    wait_cnt  = 0;
                    mem_ack_i = 1'b1;
                    if (mem_write_o) mem_lines[mem_addr_o] = mem_wdata_o;
                    else mem_rdata_i = line_of(mem_addr_o);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever a memory transfer or CPU access completes.
    initial forever begin
        cpu_exp_t e;
        mem_exp_t m;
        @(negedge clk_i);
        #1;
        if (!rst_i) begin
            if (mem_ack_i && mem_enable_o) begin
                last_ack_cyc = cyc;
                if (mem_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL mem_unexpected: got transfer to 0x%08h, required none", mem_addr_o);
                end else begin
                    m = mem_q.pop_front();
                    checkOutput("mem_write", {31'b0, mem_write_o}, {31'b0, m.write});
                    checkOutput("mem_addr", mem_addr_o, m.addr);
                    if (m.write) checkOutput("mem_wdata_w0", mem_wdata_o[31:0], m.word0);
                end
            end
            if ((cpu_read_i || cpu_write_i) && !cpu_stall_o) begin
                resp_cnt++;
                if (cpu_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL cpu_unexpected: got response 0x%08h, required none", cpu_rdata_o);
                end else begin
                    e = cpu_q.pop_front();
                    checkOutput("cpu_rdata", cpu_rdata_o, e.rdata);
                    if (e.is_hit) checkOutput("hit_latency", cyc, issue_cyc);
                    else checkOutput("miss_latency", cyc, last_ack_cyc + 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] seed;
        rst_i       = 1'b1;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        cpu_be_i    = '0;
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;
        seed        = line_of(32'h40);
        seed[63:32] = 32'hDEAD_BEEF;
        mem_lines[32'h40] = seed;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("rst_stall", {31'b0, cpu_stall_o}, 32'd0);
        checkOutput("rst_mem_enable", {31'b0, mem_enable_o}, 32'd0);
        checkOutput("rst_mem_write", {31'b0, mem_write_o}, 32'd0);
        checkOutput("rst_rdata", cpu_rdata_o, 32'd0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
        checkOutput("rst_hit_cnt", hit_cnt_o, 32'd0);
        checkOutput("rst_miss_cnt", miss_cnt_o, 32'd0);

        // Cold miss, then store/load hits on the same line.
        expectMem(1'b0, 32'h40, 32'h0);
        applyStimulus(1, 0, 32'h44, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 32'h40, 32'h1234_5678, 4'hF, 1'b1, 32'h0000_4000);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1234_5678);

        // Dirty eviction of 0x040 after filling and touching 0x440.
        expectMem(1'b0, 32'h440, 32'h0);
        applyStimulus(1, 0, 32'h440, 32'h0, 4'h0, 1'b0, 32'h0004_4000);
        applyStimulus(1, 0, 32'h440, 32'h0, 4'h0, 1'b1, 32'h0004_4000);
        expectMem(1'b1, 32'h40, 32'h1234_5678);
        expectMem(1'b0, 32'h840, 32'h0);
        applyStimulus(1, 0, 32'h840, 32'h0, 4'h0, 1'b0, 32'h0008_4000);

        // LRU: set holds 0x440/0x040, touch 0x040, 0x840 must evict 0x440.
        expectMem(1'b0, 32'h40, 32'h0);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h1234_5678);
        expectMem(1'b0, 32'h440, 32'h0);
        applyStimulus(1, 0, 32'h440, 32'h0, 4'h0, 1'b0, 32'h0004_4000);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1234_5678);
        expectMem(1'b0, 32'h840, 32'h0);
        applyStimulus(1, 0, 32'h840, 32'h0, 4'h0, 1'b0, 32'h0008_4000);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1234_5678);

        // Read+write counts as a store returning the old word; partial byte enables.
        applyStimulus(1, 1, 32'h40, 32'hAAAA_BBBB, 4'h3, 1'b1, 32'h1234_5678);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1234_BBBB);

        // Store with no byte enables allocates but leaves data alone; then a store miss.
        expectMem(1'b0, 32'h2000, 32'h0);
        applyStimulus(0, 1, 32'h2000, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0020_0000);
        applyStimulus(1, 0, 32'h2000, 32'h0, 4'h0, 1'b1, 32'h0020_0000);
        expectMem(1'b0, 32'h3000, 32'h0);
        applyStimulus(0, 1, 32'h3008, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0030_0002);
        applyStimulus(1, 0, 32'h3008, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D);
        goIdle();
        #1;
        checkOutput("hit_cnt", hit_cnt_o, exp_cnt(exp_hits));
        checkOutput("miss_cnt", miss_cnt_o, exp_cnt(exp_misses));

        // Reset in the middle of an ALLOCATE; a late ack must be ignored.
        auto_resp = 1'b0;
        @(negedge clk_i);
        cpu_read_i = 1'b1;
        cpu_addr_i = 32'h1080;
        @(negedge clk_i);
        #1;
        checkOutput("alloc_enable", {31'b0, mem_enable_o}, 32'd1);
        checkOutput("alloc_write", {31'b0, mem_write_o}, 32'd0);
        checkOutput("alloc_addr", mem_addr_o, 32'h1080);
        checkOutput("alloc_stall", {31'b0, cpu_stall_o}, 32'd1);
        rst_i      = 1'b1;
        cpu_read_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("midrst_enable", {31'b0, mem_enable_o}, 32'd0);
        checkOutput("midrst_stall", {31'b0, cpu_stall_o}, 32'd0);
        checkOutput("midrst_mem_addr", mem_addr_o, 32'd0);
        checkOutput("midrst_hit_cnt", hit_cnt_o, 32'd0);
        checkOutput("midrst_miss_cnt", miss_cnt_o, 32'd0);
        exp_hits   = 0;
        exp_misses = 0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = '1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        checkOutput("late_ack_enable", {31'b0, mem_enable_o}, 32'd0);
        checkOutput("late_ack_stall", {31'b0, cpu_stall_o}, 32'd0);
        auto_resp = 1'b1;

        // Lines that hit before reset now miss; memory holds the written-back copy.
        expectMem(1'b0, 32'h40, 32'h0);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h1234_5678);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1234_5678);
        goIdle();
        repeat (2) @(negedge clk_i);
        #1;
        checkOutput("post_hit_cnt", hit_cnt_o, exp_cnt(exp_hits));
        checkOutput("post_miss_cnt", miss_cnt_o, exp_cnt(exp_misses));
        checkOutput("cpu_q_drained", cpu_q.size(), 32'd0);
        checkOutput("mem_q_drained", mem_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
